// File: rtl/executor_movimento.sv
// Servo movement sequencer: latches a movement code, steps through its base/arm
// target table with a fixed dwell per step, then pulses completion to the control unit.
module executor_movimento #(
  parameter int unsigned T_PASSO = 25000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       aciona_movimento,
  input  logic [2:0] movimento,
  output logic       fim_movimento,
  output logic       erro_movimento,
  output logic [1:0] pos_base,
  output logic [1:0] pos_braco,
  output logic [2:0] db_estado
);

  typedef enum logic [2:0] {
    OCIOSO       = 3'b000,
    CARREGA      = 3'b001,
    POSICIONA    = 3'b010,
    PROXIMO      = 3'b011,
    FIM          = 3'b100,
    ESPERA_BAIXO = 3'b101
  } estado_t;

  localparam logic [25:0] TIMER_FIM = 26'(T_PASSO - 1);

  estado_t     estado_q, estado_d;
  logic [2:0]  codigo_q, codigo_d;
  logic [1:0]  passo_q, passo_d;
  logic [25:0] timer_q, timer_d;
  logic [1:0]  base_q, base_d;
  logic [1:0]  braco_q, braco_d;
  logic        fim_q, fim_d;
  logic        erro_q, erro_d;

  logic        codigo_valido;
  logic        ultimo;

  // Step table: {base, braco} target for a given code and step index.
  function automatic logic [3:0] alvo_passo(input logic [2:0] codigo, input logic [1:0] passo);
    logic [3:0] r;
    r = 4'b0000;
    case (codigo)
      3'd1: begin
        case (passo)
          2'd0:    r = 4'b0001;
          2'd1:    r = 4'b0101;
          2'd2:    r = 4'b0100;
          default: r = 4'b0000;
        endcase
      end
      3'd2: begin
        case (passo)
          2'd0:    r = 4'b0001;
          2'd1:    r = 4'b1001;
          2'd2:    r = 4'b1000;
          default: r = 4'b0000;
        endcase
      end
      3'd3:    r = (passo == 2'd0) ? 4'b0010 : 4'b0000;
      3'd4:    r = (passo == 2'd0) ? 4'b0100 : 4'b0000;
      default: r = 4'b0000;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] ultimo_passo(input logic [2:0] codigo);
    logic [1:0] r;
    case (codigo)
      3'd1, 3'd2: r = 2'd3;
      3'd3, 3'd4: r = 2'd1;
      default:    r = 2'd0;
    endcase
    return r;
  endfunction

  assign codigo_valido = (codigo_q < 3'd5);
  assign ultimo        = (passo_q == ultimo_passo(codigo_q));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q <= OCIOSO;
      codigo_q <= 3'd0;
      passo_q  <= 2'd0;
      timer_q  <= 26'd0;
      base_q   <= 2'b00;
      braco_q  <= 2'b00;
      fim_q    <= 1'b0;
      erro_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      codigo_q <= codigo_d;
      passo_q  <= passo_d;
      timer_q  <= timer_d;
      base_q   <= base_d;
      braco_q  <= braco_d;
      fim_q    <= fim_d;
      erro_q   <= erro_d;
    end
  end

  // fim/erro are computed for the state being entered, so their registers
  // are high exactly while the FSM sits in FIM.
  always_comb begin
    estado_d = estado_q;
    codigo_d = codigo_q;
    passo_d  = passo_q;
    timer_d  = timer_q;
    base_d   = base_q;
    braco_d  = braco_q;
    fim_d    = 1'b0;
    erro_d   = 1'b0;
    case (estado_q)
      OCIOSO: begin
        if (aciona_movimento) begin
          codigo_d = movimento;
          estado_d = CARREGA;
        end
      end
      CARREGA: begin
        passo_d = 2'd0;
        timer_d = 26'd0;
        if (codigo_valido) begin
          estado_d           = POSICIONA;
          {base_d, braco_d}  = alvo_passo(codigo_q, 2'd0);
        end else begin
          estado_d = FIM;
          fim_d    = 1'b1;
          erro_d   = 1'b1;
        end
      end
      POSICIONA: begin
        if (timer_q == TIMER_FIM) begin
          if (ultimo) begin
            estado_d = FIM;
            fim_d    = 1'b1;
          end else begin
            estado_d = PROXIMO;
          end
        end else begin
          timer_d = timer_q + 26'd1;
        end
      end
      PROXIMO: begin
        passo_d           = passo_q + 2'd1;
        timer_d           = 26'd0;
        estado_d          = POSICIONA;
        {base_d, braco_d} = alvo_passo(codigo_q, passo_q + 2'd1);
      end
      FIM: begin
        estado_d = ESPERA_BAIXO;
      end
      ESPERA_BAIXO: begin
        if (!aciona_movimento) estado_d = OCIOSO;
      end
      default: begin
        estado_d = OCIOSO;
      end
    endcase
  end

  assign fim_movimento  = fim_q;
  assign erro_movimento = erro_q;
  assign pos_base       = base_q;
  assign pos_braco      = braco_q;
  assign db_estado      = estado_q;

endmodule

// File: tb/tb_executor_movimento.sv
// Bench for executor_movimento: output events (target changes and completion
// pulses) are predicted into a queue when a request is driven and popped by a monitor.
module tb_executor_movimento;

  localparam int T = 4;
  localparam logic [17:0] ANY_T = '1;

  logic       clock = 1'b0;
  logic       reset;
  logic       aciona_movimento;
  logic [2:0] movimento;
  logic       fim_movimento;
  logic       erro_movimento;
  logic [1:0] pos_base;
  logic [1:0] pos_braco;
  logic [2:0] db_estado;

  executor_movimento #(.T_PASSO(T)) dut (
    .clock            (clock),
    .reset            (reset),
    .aciona_movimento (aciona_movimento),
    .movimento        (movimento),
    .fim_movimento    (fim_movimento),
    .erro_movimento   (erro_movimento),
    .pos_base         (pos_base),
    .pos_braco        (pos_braco),
    .db_estado        (db_estado)
  );

  // ---------------- clock / counters ----------------
  always #5 clock = ~clock;

  int edge_cnt = 0;
  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  int          n_chk  = 0;
  int          n_fail = 0;
  int          t0     = 0;
  logic        mon_en = 1'b0;
  logic [1:0]  prev_base, prev_braco;
  logic [3:0]  mdl_pos;
  // event word: {fim, erro, base, braco, edges since sampling edge}
  logic [23:0] exp_q[$];
  logic [23:0] obs_ev, exp_ev;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [3:0] tgt(input int code, input int k);
    logic [3:0] r;
    r = 4'b0000;
    if (code == 1) begin
      if (k == 0) r = 4'b0001; else if (k == 1) r = 4'b0101; else if (k == 2) r = 4'b0100;
    end else if (code == 2) begin
      if (k == 0) r = 4'b0001; else if (k == 1) r = 4'b1001; else if (k == 2) r = 4'b1000;
    end else if (code == 3) begin
      if (k == 0) r = 4'b0010;
    end else if (code == 4) begin
      if (k == 0) r = 4'b0100;
    end
    return r;
  endfunction

  function automatic int nsteps(input int code);
    case (code)
      0:       return 1;
      1, 2:    return 4;
      3, 4:    return 2;
      default: return 0;
    endcase
  endfunction

  task automatic push_move(input int code, input int limit);
    int n;
    n = nsteps(code);
    if (code > 4) begin
      exp_q.push_back({2'b11, mdl_pos, ANY_T});
    end else begin
      for (int k = 0; k < n; k++) begin
        int rel;
        logic [3:0] t;
        rel = 1 + k * (T + 1);
        t   = tgt(code, k);
        if (rel < limit) begin
          if (t != mdl_pos) exp_q.push_back({2'b00, t, 18'(rel)});
          mdl_pos = t;
        end
      end
      if ((1 + n * T + n - 1) < limit)
        exp_q.push_back({2'b10, mdl_pos, 18'(1 + n * T + n - 1)});
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clock) begin
    if (mon_en && reset) begin
      if (fim_movimento || ({pos_base, pos_braco} != {prev_base, prev_braco})) begin
        obs_ev = {fim_movimento, erro_movimento, pos_base, pos_braco, 18'(edge_cnt - t0)};
        if (exp_q.size() == 0) begin
          check("evt_unexpected", obs_ev, 0);
        end else begin
          exp_ev = exp_q.pop_front();
          if (exp_ev[17:0] == ANY_T) begin
            check("evt_err", obs_ev[23:18], exp_ev[23:18]);
            check("err_latency_le2", 32'(obs_ev[17:0] <= 18'd2), 1);
          end else begin
            check("evt", obs_ev, exp_ev);
          end
        end
      end
      prev_base  = pos_base;
      prev_braco = pos_braco;
    end
  end

  // ---------------- driver ----------------
  // Called just after a negedge with the FSM about to be in OCIOSO.
  task automatic run_move(input int code, input bit hold, input int abort_rel, input int chg_rel);
    int rel;
    int c;
    aciona_movimento = 1'b1;
    movimento        = 3'(code);
    push_move(code, (abort_rel > 0) ? abort_rel : 100000);
    @(posedge clock);
    #1;
    t0 = edge_cnt;
    check("st_carrega", db_estado, 3'b001);
    c = 0;
    while (c < 300) begin
      @(negedge clock);
      #1;
      rel = edge_cnt - t0;
      if (rel == 1 && code < 5) check("st_posiciona", db_estado, 3'b010);
      if (rel == chg_rel) begin
        movimento        = 3'd3;
        aciona_movimento = 1'b0;
      end
      if (rel == chg_rel + 1) aciona_movimento = 1'b1;
      if (abort_rel > 0 && rel == abort_rel) break;
      if (abort_rel == 0 && exp_q.size() == 0) break;
      c++;
    end
    if (exp_q.size() != 0) begin
      check("q_drain", exp_q.size(), 0);
      exp_q.delete();
    end
    if (abort_rel == 0 && !hold) begin
      aciona_movimento = 1'b0;
      repeat (2) @(negedge clock);
      #1;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset            = 1'b0;
    aciona_movimento = 1'b0;
    movimento        = 3'd0;
    mdl_pos          = 4'b0000;
    prev_base        = 2'b00;
    prev_braco       = 2'b00;
    #12;
    check("rst_fim", fim_movimento, 0);
    check("rst_erro", erro_movimento, 0);
    check("rst_base", pos_base, 2'b00);
    check("rst_braco", pos_braco, 2'b00);
    check("rst_estado", db_estado, 3'b000);
    @(negedge clock);
    reset  = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(negedge clock);
    #1;

    run_move(0, 0, 0, 1000);   // HOME
    run_move(1, 0, 0, 1000);   // GIRA_H
    run_move(6, 0, 0, 1000);   // invalid
    run_move(2, 0, 0, 1000);   // GIRA_AH
    run_move(4, 0, 0, 1000);   // ROTACIONA_CUBO

    // held request after completion must not retrigger
    run_move(0, 1, 0, 1000);
    repeat (10) @(negedge clock);
    #1;
    check("hold_espera", db_estado, 3'b101);
    aciona_movimento = 1'b0;
    @(negedge clock);
    #1;
    run_move(3, 0, 0, 1000);   // TOMBA

    // input changes mid-movement are ignored
    run_move(1, 0, 0, 7);
    run_move(7, 0, 0, 1000);

    // reset during step 2 of GIRA_AH
    run_move(2, 0, 8, 1000);
    check("pre_abort_pos", {pos_base, pos_braco}, 4'b1001);
    mon_en           = 1'b0;
    aciona_movimento = 1'b0;
    reset            = 1'b0;
    #1;
    check("abort_base", pos_base, 2'b00);
    check("abort_braco", pos_braco, 2'b00);
    check("abort_estado", db_estado, 3'b000);
    check("abort_fim", fim_movimento, 0);
    #1;
    reset      = 1'b1;
    mdl_pos    = 4'b0000;
    prev_base  = 2'b00;
    prev_braco = 2'b00;
    mon_en     = 1'b1;
    repeat (50) @(negedge clock);
    #1;
    check("post_abort_estado", db_estado, 3'b000);

    for (int i = 0; i < 6; i++) run_move($urandom_range(0, 7), 0, 0, 1000);

    check("q_empty_end", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
